// File: rtl/mem_port_arbiter_pkg.sv
// Shared core constants and types for the memory port arbiter and its committed-store FIFO.
package mem_port_arbiter_pkg;

    localparam int LOAD_WAIT_DEF    = 2;
    localparam int SFIFO_DEPTH_DEF  = 4;
    localparam int STARVE_LIMIT_DEF = 8;
    localparam int ADDR_W           = 16;
    localparam int DATA_W           = 16;
    localparam int ROB_W            = 6;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ROB_W-1:0]  rob_t;

    // Which requester owns the single memory port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_LOAD  = 2'd1,
        GNT_STORE = 2'd2
    } grant_e;

endpackage

// File: rtl/commit_store_fifo.sv
// Circular FIFO of committed stores with a combinational youngest-match search
// used for store-to-load forwarding.
module commit_store_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = SFIFO_DEPTH_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  addr_t push_addr_i,
    input  data_t push_data_i,
    input  logic  pop_i,
    input  addr_t search_addr_i,
    output logic  full_o,
    output logic  empty_o,
    output addr_t head_addr_o,
    output data_t head_data_o,
    output logic  hit_o,
    output data_t hit_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    addr_t            addr_q [DEPTH];
    data_t            data_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] slot_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so later hits override earlier ones; the head being
    // popped this cycle is already in memory, and a same-cycle push is youngest.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((k < int'(count_q)) && !(do_pop && (k == 0)) &&
                (addr_q[slot_idx(rd_ptr_q, k)] == search_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[slot_idx(rd_ptr_q, k)];
            end
        end
        if (do_push && (push_addr_i == search_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: loads take priority, committed stores drain from a FIFO
// and are forced through when the FIFO fills or a store has waited too long.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LOAD_WAIT    = LOAD_WAIT_DEF,
    parameter int SFIFO_DEPTH  = SFIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ROB_W-1:0]  ld_rob,
    output logic              ld_stall,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ROB_W-1:0]  resp_rob
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    grant_e           grant;
    logic             fifo_full;
    logic             fifo_empty;
    addr_t            head_addr;
    data_t            head_data;
    logic             fwd_hit;
    data_t            fwd_data;
    logic             force_store;
    logic [STV_W-1:0] starve_q, starve_d;

    logic  vld_q      [LOAD_WAIT];
    logic  vld_d      [LOAD_WAIT];
    rob_t  rob_q      [LOAD_WAIT];
    rob_t  rob_d      [LOAD_WAIT];
    logic  fwd_q      [LOAD_WAIT];
    logic  fwd_d      [LOAD_WAIT];
    data_t fwd_data_q [LOAD_WAIT];
    data_t fwd_data_d [LOAD_WAIT];

    commit_store_fifo #(
        .DEPTH (SFIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (st_valid),
        .push_addr_i   (st_addr),
        .push_data_i   (st_data),
        .pop_i         (grant == GNT_STORE),
        .search_addr_i (ld_addr),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .hit_o         (fwd_hit),
        .hit_data_o    (fwd_data)
    );

    assign force_store = fifo_full || (starve_q == STV_W'(STARVE_LIMIT));
    assign ld_stall    = force_store && !rst;
    assign st_ready    = !fifo_full || rst;

    always_comb begin
        grant = GNT_NONE;
        if (rst) begin
            grant = GNT_NONE;
        end else if (ld_valid && !force_store && !flush) begin
            grant = GNT_LOAD;
        end else if (!fifo_empty) begin
            grant = GNT_STORE;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (grant)
            GNT_LOAD: begin
                mem_en   = 1'b1;
                mem_addr = ld_addr;
            end
            GNT_STORE: begin
                mem_en    = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || (grant == GNT_STORE)) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Stage 0 captures the grant; the last stage lines up with mem_rdata.
    always_comb begin
        vld_d[0]      = (grant == GNT_LOAD);
        rob_d[0]      = ld_rob;
        fwd_d[0]      = fwd_hit;
        fwd_data_d[0] = fwd_data;
        for (int i = 1; i < LOAD_WAIT; i++) begin
            vld_d[i]      = vld_q[i-1];
            rob_d[i]      = rob_q[i-1];
            fwd_d[i]      = fwd_q[i-1];
            fwd_data_d[i] = fwd_data_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < LOAD_WAIT; i++) vld_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            for (int i = 0; i < LOAD_WAIT; i++) begin
                vld_q[i]      <= 1'b0;
                rob_q[i]      <= '0;
                fwd_q[i]      <= 1'b0;
                fwd_data_q[i] <= '0;
            end
        end else begin
            starve_q <= starve_d;
            for (int i = 0; i < LOAD_WAIT; i++) begin
                vld_q[i]      <= vld_d[i];
                rob_q[i]      <= rob_d[i];
                fwd_q[i]      <= fwd_d[i];
                fwd_data_q[i] <= fwd_data_d[i];
            end
        end
    end

    assign resp_valid = vld_q[LOAD_WAIT-1] && !rst;
    assign resp_rob   = resp_valid ? rob_q[LOAD_WAIT-1] : '0;
    assign resp_data  = !resp_valid ? '0 :
                        (fwd_q[LOAD_WAIT-1] ? fwd_data_q[LOAD_WAIT-1] : mem_rdata);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the steady-state path and
// hand-written sequences for full FIFO, starvation, flush and mid-run reset.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LW = LOAD_WAIT_DEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [5:0]  ld_rob;
    logic        ld_stall;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ready;
    logic        mem_en;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [5:0]  resp_rob;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_rob     (ld_rob),
        .ld_stall   (ld_stall),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rob   (resp_rob)
    );

    // Memory model: fixed read latency, data sampled at the grant edge.
    logic [15:0] mem [0:65535];
    logic [15:0] rd_pipe [LW];

    always @(posedge clk) begin
        if (mem_en && mem_wen) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LW; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LW-1];

    int checks = 0;
    int errors = 0;

    // Expected memory writes, {addr, data}, in order.
    logic [31:0] exp_q[$];
    logic [31:0] wr_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en && mem_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_sb: unexpected write addr %h data %h", mem_addr, mem_wdata);
            end else begin
                wr_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== wr_exp) begin
                    errors++;
                    $display("FAIL write_sb: got %h expected %h", {mem_addr, mem_wdata}, wr_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic lv, input logic [15:0] la, input logic [5:0] lr,
                          input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                          input logic fl);
        ld_valid = lv;
        ld_addr  = la;
        ld_rob   = lr;
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        flush    = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 16'h0000, 6'd0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    typedef struct {
        logic        lv;
        logic [15:0] la;
        logic [5:0]  lr;
        logic        sv;
        logic [15:0] sa;
        logic [15:0] sd;
        logic        e_en;
        logic        e_wen;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_rv;
        logic [5:0]  e_rob;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t tbl [21];

    task automatic run_starve(input logic [15:0] sa, input logic [15:0] sd);
        set_in(1'b1, 16'h0400, 6'd2, 1'b1, sa, sd, 1'b0);
        @(negedge clk);
        chk("B push ld_stall", ld_stall, 0);
        chk("B push mem_wen", mem_wen, 0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            set_in(1'b1, 16'h0400, 6'd2, 1'b0, 16'h0000, 16'h0000, 1'b0);
            @(negedge clk);
            chk($sformatf("B wait%0d ld_stall", k), ld_stall, 0);
            chk($sformatf("B wait%0d mem_wen", k), mem_wen, 0);
            tick();
        end
        @(negedge clk);
        chk("B forced ld_stall", ld_stall, 1);
        chk("B forced mem_wen", mem_wen, 1);
        chk("B forced mem_addr", mem_addr, sa);
        chk("B forced mem_wdata", mem_wdata, sd);
        tick();
        @(negedge clk);
        chk("B after ld_stall", ld_stall, 0);
        chk("B after mem_en", mem_en, 1);
        chk("B after mem_wen", mem_wen, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b1, 16'h0010, 6'd3, 1'b1, 16'h0ABC, 16'h0DEF, 1'b0);
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0030] = 16'hCAFE;
        for (int i = 0; i < LW; i++) rd_pipe[i] = 16'h0000;

        exp_q = '{32'h0020_1234, 32'h0020_0001, 32'h0020_0002, 32'h0040_00AA,
                  32'h0200_0001, 32'h0201_0002, 32'h0202_0003, 32'h0203_0004,
                  32'h0300_0055, 32'h0301_0056, 32'h0700_0077};

        //         lv    la        lr     sv    sa        sd         en    wen   addr      wdata      rv    rob    rdata
        tbl[0]  = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[2]  = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[3]  = '{1'b1, 16'h0010, 6'd5,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[5]  = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 6'd5,  16'hBEEF};
        tbl[6]  = '{1'b0, 16'h0000, 6'd0,  1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[7]  = '{1'b1, 16'h0020, 6'd7,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[8]  = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 6'd0,  16'h0000};
        tbl[9]  = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 6'd7,  16'h1234};
        tbl[10] = '{1'b0, 16'h0000, 6'd0,  1'b1, 16'h0020, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[11] = '{1'b1, 16'h0030, 6'd8,  1'b1, 16'h0020, 16'h0002, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[12] = '{1'b1, 16'h0020, 6'd9,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[13] = '{1'b1, 16'h0040, 6'd10, 1'b1, 16'h0040, 16'h00AA, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 6'd8,  16'hCAFE};
        tbl[14] = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h0001, 1'b1, 6'd9,  16'h0002};
        tbl[15] = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h0002, 1'b1, 6'd10, 16'h00AA};
        tbl[16] = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h00AA, 1'b0, 6'd0,  16'h0000};
        tbl[17] = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[18] = '{1'b1, 16'h0040, 6'd11, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[19] = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 6'd0,  16'h0000};
        tbl[20] = '{1'b0, 16'h0000, 6'd0,  1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 6'd11, 16'h00AA};

        // Reset state, with requests pending on every input.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ld_stall", ld_stall, 0);
        chk("rst st_ready", st_ready, 1);
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_wen", mem_wen, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_rob", resp_rob, 0);
        chk("rst resp_data", resp_data, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            set_in(tbl[i].lv, tbl[i].la, tbl[i].lr, tbl[i].sv, tbl[i].sa, tbl[i].sd, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d mem_en", i), mem_en, tbl[i].e_en);
            chk($sformatf("v%0d mem_wen", i), mem_wen, tbl[i].e_wen);
            chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_wdata);
            chk($sformatf("v%0d ld_stall", i), ld_stall, 0);
            chk($sformatf("v%0d st_ready", i), st_ready, 1);
            chk($sformatf("v%0d resp_valid", i), resp_valid, tbl[i].e_rv);
            chk($sformatf("v%0d resp_rob", i), resp_rob, tbl[i].e_rob);
            chk($sformatf("v%0d resp_data", i), resp_data, tbl[i].e_rdata);
            tick();
        end

        // Fill the FIFO behind a continuous load stream.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 16'h0100, 6'd1, 1'b1, 16'h0200 + 16'(k), 16'(k + 1), 1'b0);
            @(negedge clk);
            chk($sformatf("A fill%0d ld_stall", k), ld_stall, 0);
            chk($sformatf("A fill%0d st_ready", k), st_ready, 1);
            chk($sformatf("A fill%0d mem_wen", k), mem_wen, 0);
            chk($sformatf("A fill%0d mem_addr", k), mem_addr, 16'h0100);
            tick();
        end
        set_in(1'b1, 16'h0100, 6'd1, 1'b1, 16'h0299, 16'h0099, 1'b0);
        @(negedge clk);
        chk("A full ld_stall", ld_stall, 1);
        chk("A full st_ready", st_ready, 0);
        chk("A full mem_wen", mem_wen, 1);
        chk("A full mem_addr", mem_addr, 16'h0200);
        chk("A full mem_wdata", mem_wdata, 16'h0001);
        tick();
        set_in(1'b1, 16'h0100, 6'd1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        chk("A resume ld_stall", ld_stall, 0);
        chk("A resume st_ready", st_ready, 1);
        chk("A resume mem_en", mem_en, 1);
        chk("A resume mem_wen", mem_wen, 0);
        tick();
        for (int k = 1; k < 4; k++) begin
            idle();
            @(negedge clk);
            chk($sformatf("A drain%0d mem_wen", k), mem_wen, 1);
            chk($sformatf("A drain%0d mem_addr", k), mem_addr, 16'h0200 + 16'(k));
            tick();
        end
        idle();
        @(negedge clk);
        chk("A empty mem_en", mem_en, 0);
        tick();
        tick();

        // Starvation: a single store behind continuous loads, twice in a row.
        run_starve(16'h0300, 16'h0055);
        run_starve(16'h0301, 16'h0056);
        idle();
        tick();
        tick();
        tick();

        // Flush kills the in-flight load but the pending store still drains.
        set_in(1'b0, 16'h0000, 6'd0, 1'b1, 16'h0700, 16'h0077, 1'b0);
        @(negedge clk);
        chk("C push mem_en", mem_en, 0);
        tick();
        set_in(1'b1, 16'h0500, 6'd12, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        chk("C load mem_en", mem_en, 1);
        chk("C load mem_wen", mem_wen, 0);
        chk("C load mem_addr", mem_addr, 16'h0500);
        tick();
        set_in(1'b1, 16'h0600, 6'd13, 1'b0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        chk("C flush mem_wen", mem_wen, 1);
        chk("C flush mem_addr", mem_addr, 16'h0700);
        chk("C flush ld_stall", ld_stall, 0);
        tick();
        idle();
        @(negedge clk);
        chk("C killed resp_valid", resp_valid, 0);
        tick();
        @(negedge clk);
        chk("C suppressed resp_valid", resp_valid, 0);
        chk("C idle mem_en", mem_en, 0);
        tick();

        // Mid-run reset with three queued stores and loads in flight.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 16'h0900, 6'd20, 1'b1, 16'h0800 + 16'(k), 16'h0011 + 16'(k), 1'b0);
            @(negedge clk);
            chk($sformatf("D queue%0d mem_wen", k), mem_wen, 0);
            tick();
        end
        set_in(1'b1, 16'h0900, 6'd21, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        chk("D inflight mem_en", mem_en, 1);
        chk("D inflight mem_wen", mem_wen, 0);
        tick();
        rst = 1'b1;
        set_in(1'b1, 16'h0900, 6'd22, 1'b1, 16'h0ABC, 16'h0DEF, 1'b0);
        @(negedge clk);
        chk("D rst mem_en", mem_en, 0);
        chk("D rst mem_wen", mem_wen, 0);
        chk("D rst ld_stall", ld_stall, 0);
        chk("D rst st_ready", st_ready, 1);
        chk("D rst resp_valid", resp_valid, 0);
        chk("D rst resp_rob", resp_rob, 0);
        chk("D rst resp_data", resp_data, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            idle();
            @(negedge clk);
            chk($sformatf("D post%0d mem_en", k), mem_en, 0);
            chk($sformatf("D post%0d mem_wen", k), mem_wen, 0);
            chk($sformatf("D post%0d resp_valid", k), resp_valid, 0);
            chk($sformatf("D post%0d st_ready", k), st_ready, 1);
            tick();
        end

        chk("write_sb drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
